// File: rtl/picorv32_mem_pkg.sv
// Shared types and constants for the picorv32 memory slave.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package picorv32_mem_pkg;

    localparam int          WAIT_CNT_W       = 4;
    localparam int          DEF_DEPTH_WORDS  = 256;
    localparam logic [31:0] DEF_BASE_ADDR    = 32'h0000_0000;
    localparam int          DEF_WAIT_STATES  = 0;
    localparam logic [31:0] DEF_CONSOLE_ADDR = 32'h1000_0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

endpackage

// File: rtl/picorv32_mem_slave_if.sv
// picorv32 native memory request/response bundle, plus the unmapped-access flag.
// Latency: n/a (wires only).
// Backpressure: slave stalls the master by withholding mem_ready.
interface picorv32_mem_slave_if;

    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        bus_err;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata, bus_err
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata, bus_err
    );

endinterface

// File: rtl/picorv32_mem_array.sv
// Word RAM with byte-lane writes on the bus port and a full-word preload port.
// Latency: combinational read, writes land on the rising edge.
// Backpressure: none; both ports accept every cycle.
module picorv32_mem_array
    import picorv32_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS
) (
    input  logic                           clk,
    input  logic [$clog2(DEPTH_WORDS)-1:0] rw_addr,
    input  logic [3:0]                     rw_we,
    input  logic [31:0]                    rw_wdata,
    output logic [31:0]                    rw_rdata,
    input  logic                           ld_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
    input  logic [31:0]                    ld_data
);

    logic [31:0] mem [DEPTH_WORDS];

    assign rw_rdata = mem[rw_addr];

    // Bus lanes are assigned after the preload so they win on a same-word collision.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
        for (int b = 0; b < 4; b++) begin
            if (rw_we[b]) begin
                mem[rw_addr][8*b +: 8] <= rw_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/picorv32_mem_slave.sv
// picorv32 native-bus RAM slave with optional console port (MEM_CONSOLE_EN).
// Latency: mem_ready one cycle after the request edge plus WAIT_STATES.
// Backpressure: holds mem_ready low during wait states; dropping mem_valid aborts.
module picorv32_mem_slave
    import picorv32_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS  = DEF_DEPTH_WORDS,
    parameter logic [31:0] BASE_ADDR    = DEF_BASE_ADDR,
    parameter int          WAIT_STATES  = DEF_WAIT_STATES,
    parameter logic [31:0] CONSOLE_ADDR = DEF_CONSOLE_ADDR
) (
    input  logic                           clk,
    input  logic                           reset,
    picorv32_mem_slave_if.slave            bus,
    input  logic                           load_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
    input  logic [31:0]                    load_data
`ifdef MEM_CONSOLE_EN
    ,
    output logic                           console_valid,
    output logic [7:0]                     console_data
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);

    mem_state_t            state_q;
    logic [WAIT_CNT_W-1:0] cnt_q;
    mem_req_t              req_q;
    mem_req_t              cur_req;
    logic [AW-1:0]         word_idx;
    logic                  in_range;
    logic                  console_hit;
    logic                  mapped;
    logic                  commit;
    logic [3:0]            ram_we;
    logic [31:0]           ram_rdata;
    logic                  unused_bits;

    // With no wait states the request is served straight off the bus in IDLE.
    always_comb begin
        cur_req = req_q;
        if (state_q == IDLE) begin
            cur_req = '{addr: bus.mem_addr, wdata: bus.mem_wdata, wstrb: bus.mem_wstrb};
        end
    end

    assign word_idx    = cur_req.addr[AW+1:2];
    assign in_range    = (cur_req.addr[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign console_hit = (cur_req.addr[31:2] == CONSOLE_ADDR[31:2]);
    assign commit      = !reset && bus.mem_valid &&
                         ((state_q == IDLE && WAIT_STATES == 0) ||
                          (state_q == WAIT && cnt_q == '0));
    assign ram_we      = (commit && in_range) ? cur_req.wstrb : 4'b0000;

`ifdef MEM_CONSOLE_EN
    logic console_fire;
    assign mapped       = in_range || console_hit;
    assign console_fire = commit && console_hit && cur_req.wstrb[0];
    assign unused_bits  = ^{bus.mem_instr, cur_req.addr[1:0]};
`else
    assign mapped       = in_range;
    assign unused_bits  = ^{bus.mem_instr, cur_req.addr[1:0], console_hit};
`endif

    picorv32_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk      (clk),
        .rw_addr  (word_idx),
        .rw_we    (ram_we),
        .rw_wdata (cur_req.wdata),
        .rw_rdata (ram_rdata),
        .ld_en    (load_en),
        .ld_addr  (load_addr),
        .ld_data  (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            req_q         <= '0;
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= '0;
            bus.bus_err   <= 1'b0;
`ifdef MEM_CONSOLE_EN
            console_valid <= 1'b0;
            console_data  <= '0;
`endif
        end else begin
            bus.mem_ready <= commit;
            bus.mem_rdata <= (commit && in_range) ? ram_rdata : '0;
            bus.bus_err   <= commit && !mapped;
`ifdef MEM_CONSOLE_EN
            console_valid <= console_fire;
            console_data  <= console_fire ? cur_req.wdata[7:0] : '0;
`endif
            case (state_q)
                IDLE: begin
                    if (bus.mem_valid) begin
                        req_q <= cur_req;
                        if (WAIT_STATES == 0) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= WAIT_CNT_W'(WAIT_STATES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (!bus.mem_valid) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == '0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_picorv32_mem_slave.sv
// Bench for picorv32_mem_slave: three instances at 0/3/5 wait states against a word-array model.
// Latency: checks mem_ready lands exactly WAIT_STATES+1 edges after the request edge.
// Backpressure: exercises mid-wait aborts via mem_valid drop and reset.
`timescale 1ns/1ps
module tb_picorv32_mem_slave;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] CONS  = 32'h1000_0000;
    localparam int          LAT [3] = '{0, 3, 5};
`ifdef MEM_CONSOLE_EN
    localparam bit CONS_EN = 1'b1;
`else
    localparam bit CONS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       rst, valid, instr, ld_en;
    logic [2:0][31:0] addr, wdata, ld_data;
    logic [2:0][3:0]  wstrb;
    logic [2:0][7:0]  ld_addr;
    wire  [2:0]       ready, err;
    wire  [2:0][31:0] rdata;
`ifdef MEM_CONSOLE_EN
    wire  [2:0]       cvld;
    wire  [2:0][7:0]  cdat;
`endif

    for (genvar g = 0; g < 3; g++) begin : g_dut
        picorv32_mem_slave_if bus ();
        assign bus.mem_valid = valid[g];
        assign bus.mem_instr = instr[g];
        assign bus.mem_addr  = addr[g];
        assign bus.mem_wdata = wdata[g];
        assign bus.mem_wstrb = wstrb[g];
        assign ready[g]      = bus.mem_ready;
        assign rdata[g]      = bus.mem_rdata;
        assign err[g]        = bus.bus_err;

        picorv32_mem_slave #(
            .DEPTH_WORDS  (DEPTH),
            .BASE_ADDR    (BASE),
            .WAIT_STATES  (LAT[g]),
            .CONSOLE_ADDR (CONS)
        ) dut (
            .clk          (clk),
            .reset        (rst[g]),
            .bus          (bus),
            .load_en      (ld_en[g]),
            .load_addr    (ld_addr[g]),
            .load_data    (ld_data[g])
`ifdef MEM_CONSOLE_EN
            ,
            .console_valid (cvld[g]),
            .console_data  (cdat[g])
`endif
        );
    end

    int          tests = 0;
    int          fails = 0;
    logic [31:0] model [3][DEPTH];
    logic [31:0] last_rd;
    logic        last_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic chk_idle(input int n, input string tag);
        chk({tag, "/ready"}, 32'(ready[n]), 32'd0);
        chk({tag, "/rdata"}, rdata[n], 32'd0);
        chk({tag, "/err"}, 32'(err[n]), 32'd0);
`ifdef MEM_CONSOLE_EN
        chk({tag, "/cvld"}, 32'(cvld[n]), 32'd0);
        chk({tag, "/cdat"}, 32'(cdat[n]), 32'd0);
`endif
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic load(input int n, input int idx, input logic [31:0] d);
        ld_en[n] = 1'b1; ld_addr[n] = idx[7:0]; ld_data[n] = d;
        @(negedge clk);
        ld_en[n] = 1'b0;
        model[n][idx] = d;
    endtask

    task automatic access(input int n, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input bit ld, input logic [31:0] ldd,
                          input string tag);
        bit          hit, cons;
        int          idx;
        logic [31:0] exp_rd;
        hit    = (a >= BASE) && ((a - BASE) < 32'(4 * DEPTH));
        idx    = hit ? int'((a - BASE) >> 2) : 0;
        cons   = CONS_EN && ((a >> 2) == (CONS >> 2));
        exp_rd = !hit ? 32'd0 : (ld && LAT[n] != 0) ? ldd : model[n][idx];
        valid[n] = 1'b1; instr[n] = 1'($urandom); addr[n] = a; wdata[n] = wd; wstrb[n] = ws;
        if (ld) begin
            ld_en[n] = 1'b1; ld_addr[n] = idx[7:0]; ld_data[n] = ldd;
        end
        for (int j = 0; j <= LAT[n]; j++) begin
            @(negedge clk);
            ld_en[n] = 1'b0;
            chk({tag, "/ready_timing"}, 32'(ready[n]), 32'(j == LAT[n]));
        end
        last_rd  = rdata[n];
        last_err = err[n];
        chk({tag, "/rdata"}, rdata[n], exp_rd);
        chk({tag, "/bus_err"}, 32'(err[n]), 32'(!(hit || cons)));
`ifdef MEM_CONSOLE_EN
        chk({tag, "/cvld"}, 32'(cvld[n]), 32'(cons && ws[0]));
        if (cons && ws[0]) chk({tag, "/cdat"}, 32'(cdat[n]), 32'(wd[7:0]));
`endif
        valid[n] = 1'b0; wstrb[n] = 4'd0;
        if (ld) model[n][idx] = ldd;
        if (hit) model[n][idx] = merge(model[n][idx], wd, ws);
        @(negedge clk);
        chk_idle(n, {tag, "/after"});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 3'b111; valid = '0; instr = '0; ld_en = '0;
        addr = '0; wdata = '0; wstrb = '0; ld_addr = '0; ld_data = '0;
        repeat (3) @(negedge clk);
        rst = 3'b000;
        for (int n = 0; n < 3; n++) chk_idle(n, "reset");

        // Random preload of every word in all three instances.
        for (int i = 0; i < DEPTH; i++) begin
            for (int n = 0; n < 3; n++) begin
                ld_addr[n] = 8'(i); ld_data[n] = $urandom; model[n][i] = ld_data[n];
            end
            ld_en = 3'b111;
            @(negedge clk);
        end
        ld_en = 3'b000;

        load(0, 0, 32'h0070_0093);
        access(0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, "w0_read");
        chk("w0_read_value", last_rd, 32'h0070_0093);

        load(1, 4, 32'h0);
        access(1, 32'h10, 32'hDEAD_BEEF, 4'b0101, 1'b0, 32'h0, "w3_write");
        access(1, 32'h10, 32'h0, 4'h0, 1'b0, 32'h0, "w3_readback");
        chk("w3_readback_value", last_rd, 32'h00AD_00EF);

        access(0, 32'h400, $urandom, 4'hF, 1'b0, 32'h0, "unmapped");
        access(0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, "unmapped_alias");
        chk("unmapped_alias_value", last_rd, 32'h0070_0093);

        access(0, 32'h1000_0000, 32'h0000_0041, 4'b0001, 1'b0, 32'h0, "console");
        chk("console_err", 32'(last_err), 32'(!CONS_EN));

        access(0, 32'h14, 32'hA1B2_C3D4, 4'b0011, 1'b1, 32'h1122_3344, "collide");
        access(0, 32'h14, 32'h0, 4'h0, 1'b0, 32'h0, "collide_rd");
        chk("collide_value", last_rd, 32'h1122_C3D4);

        // Reset two cycles into a 5-wait-state write.
        valid[2] = 1'b1; addr[2] = 32'h20; wdata[2] = $urandom; wstrb[2] = 4'hF;
        @(negedge clk);
        chk("rst_mid/ready0", 32'(ready[2]), 32'd0);
        @(negedge clk);
        chk("rst_mid/ready1", 32'(ready[2]), 32'd0);
        rst[2] = 1'b1;
        @(negedge clk);
        chk_idle(2, "rst_mid/outputs");
        rst[2] = 1'b0; valid[2] = 1'b0; wstrb[2] = 4'd0;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            chk("rst_mid/no_ready", 32'(ready[2]), 32'd0);
        end
        access(2, 32'h20, 32'h0, 4'h0, 1'b0, 32'h0, "rst_mid_rd");

        // Drop mem_valid inside the wait window, then re-request straight away.
        valid[2] = 1'b1; addr[2] = 32'h24; wdata[2] = $urandom; wstrb[2] = 4'hF;
        @(negedge clk);
        chk("drop/ready0", 32'(ready[2]), 32'd0);
        @(negedge clk);
        chk("drop/ready1", 32'(ready[2]), 32'd0);
        valid[2] = 1'b0; wstrb[2] = 4'd0;
        @(negedge clk);
        chk_idle(2, "drop/aborted");
        access(2, 32'h24, 32'h0, 4'h0, 1'b0, 32'h0, "drop_new");

        for (int r = 0; r < 60; r++) begin
            int          n, kind;
            logic [31:0] a;
            logic [3:0]  ws;
            n    = r % 3;
            kind = $urandom_range(0, 9);
            if (kind < 8)       a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4) + 32'($urandom_range(0, 3));
            else if (kind == 8) a = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFC);
            else                a = CONS;
            ws = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            access(n, a, $urandom, ws, 1'b0, 32'h0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/picorv32_mem_slave.md
PICORV32_MEM_SLAVE -- requirements
Module: picorv32_mem_slave

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit words, power of two, 16..65536.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0, aligned to 4*DEPTH_WORDS.
REQ-003 SHALL have parameter WAIT_STATES, default 0: extra cycles before mem_ready, range 0..15.
REQ-004 SHALL have parameter CONSOLE_ADDR, default 32'h1000_0000: byte address of the console port, outside the RAM window.
REQ-005 SHALL have one clock and a synchronous, active-high reset.
REQ-006 SHALL have port clk, input, 1: clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-008 SHALL have ports mem_valid (in, 1), mem_instr (in, 1), mem_addr (in, 32), mem_wdata (in, 32) and mem_wstrb (in, 4): picorv32 native request.
REQ-009 SHALL have ports mem_ready (out, 1) and mem_rdata (out, 32): response, both registered.
REQ-010 SHALL have port bus_err, output, 1: one-cycle pulse on an unmapped access.
REQ-011 SHALL have ports load_en (in, 1), load_addr (in, $clog2(DEPTH_WORDS)) and load_data (in, 32): bench preload, word-indexed.
REQ-012 SHALL have ports console_valid (out, 1) and console_data (out, 8), present only under MEM_CONSOLE_EN.

Function
REQ-013 SHALL implement FSM IDLE -> (WAIT) -> RESP -> IDLE.
- IDLE with mem_valid=1: capture the request.
- If WAIT_STATES=0: go to RESP.
- Otherwise: go to WAIT with the counter loaded to WAIT_STATES-1.
REQ-014 WAIT SHALL decrement the counter each cycle and go to RESP when the counter reaches 0.
REQ-015 Request sampled at edge k: mem_ready SHALL be high for exactly one cycle, starting after edge k+WAIT_STATES.
REQ-016 RESP SHALL return to IDLE unconditionally; mem_valid in the cycle after a response is treated as a new request.
REQ-017 In-range access (BASE_ADDR <= addr < BASE_ADDR+4*DEPTH_WORDS): word index SHALL be addr[..:2]-relative; addr[1:0] is ignored.
REQ-018 Write (mem_wstrb != 0): update only strobed byte lanes, on the same edge mem_ready rises.
REQ-019 mem_rdata SHALL hold the pre-write word content; it is also returned for writes.
REQ-020 mem_instr SHALL NOT affect behaviour.
REQ-021 Unmapped access: mem_ready SHALL still be given with the same latency; mem_rdata=0, no write, bus_err high in the same cycle as mem_ready.
REQ-022 If mem_valid drops while in WAIT: return to IDLE, no write, no mem_ready, no bus_err.
REQ-023 load_en=1: write load_data to word load_addr at the edge, in any state.
- If load_en and a bus write commit hit the same word on the same edge, the bus write bytes win; unstrobed bytes take load_data.
REQ-024 mem_rdata SHALL be 0 whenever mem_ready is 0.

Reset
REQ-025 reset=1 SHALL force IDLE, counter=0, and mem_ready, mem_rdata, bus_err, console_valid and console_data to 0 at the next edge.
REQ-026 Reset mid-WAIT SHALL abort the access with no write; RAM contents are not cleared by reset.

Configuration
REQ-027 With MEM_CONSOLE_EN defined:
- A write to CONSOLE_ADDR with mem_wstrb[0]=1 pulses console_valid for one cycle, coincident with mem_ready, with console_data=mem_wdata[7:0].
- Any access to CONSOLE_ADDR is mapped (no bus_err); reads return 0.
REQ-028 Without MEM_CONSOLE_EN: the console ports are absent and CONSOLE_ADDR is treated as unmapped.

Structure
REQ-029 Package picorv32_mem_pkg SHALL hold:
- the FSM state enum (IDLE, WAIT, RESP);
- the wait-counter width constant (4);
- default parameter constants.
REQ-030 Storage SHALL be a sub-module picorv32_mem_array: byte-lane write-enabled RAM with one read/write port and one preload write port.

Verification
REQ-031 WAIT_STATES=0: load_en word 0 = 32'h0070_0093; read addr 0x0 -> mem_ready high exactly one cycle after request edge, mem_rdata=32'h0070_0093.
REQ-032 WAIT_STATES=3: write 32'hDEAD_BEEF, wstrb=4'b0101, to addr 0x10 (preloaded 0) -> ready after edge k+3; readback = 32'h00AD_00EF.
REQ-033 Read addr 4*DEPTH_WORDS (0x400 at defaults) -> mem_ready and bus_err together for one cycle, mem_rdata=0, RAM unchanged.
REQ-034 MEM_CONSOLE_EN: write 32'h0000_0041 to 0x1000_0000 -> console_valid one cycle, console_data=8'h41, bus_err=0; without the macro -> bus_err=1.
REQ-035 WAIT_STATES=5: assert reset two cycles into a write to 0x20 -> no mem_ready; after reset, word 0x20 holds its old value and all outputs are 0.
REQ-036 WAIT_STATES=5: drop mem_valid during WAIT -> no mem_ready; a new request on the next cycle completes with normal latency.
